// File: rtl/phase_pkg.sv
// Shared types and constants for the dual-rail phase ring receiver.
package phase_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_NULL, ERR} state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef logic [1:0] ph_idx_t;

  localparam ph_idx_t PH0 = 2'd0;
  localparam ph_idx_t PH1 = 2'd1;
  localparam ph_idx_t PH2 = 2'd2;

  function automatic ph_idx_t ph_inc(input ph_idx_t p);
    return (p == PH2) ? PH0 : ph_idx_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Synchroniser plus two-sample stability filter for one 2-bit dual-rail bus.
module dr_sync
  import phase_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  output logic [1:0] word,
  output logic       stable
);

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= DR_NULL;
      filt_q <= DR_NULL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      filt_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Codeword is trusted only once two consecutive synchronised samples agree.
  assign word   = filt_q;
  assign stable = (sync_q[SYNC_STAGES-1] == filt_q);

endmodule

// File: rtl/phase_rx.sv
// Clocked receiver closing the dual-rail phase ring handshake: PH0 -> PH1 -> PH2
// tokens become one-cycle strobes, op_done completion becomes the ring ack.
module phase_rx
  import phase_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ph0,
  input  logic [1:0]       ph1,
  input  logic [1:0]       ph2,
  input  logic             op_done,
  output logic             ack,
  output logic [2:0]       ph_strobe,
  output logic             ph_bit,
  output logic             err,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0] word [3];
  logic [2:0] stable;

  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk(clk), .rst_n(rst_n), .din(ph0), .word(word[0]), .stable(stable[0])
  );
  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk(clk), .rst_n(rst_n), .din(ph1), .word(word[1]), .stable(stable[1])
  );
  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
    .clk(clk), .rst_n(rst_n), .din(ph2), .word(word[2]), .stable(stable[2])
  );

  logic [2:0] is_valid, is_ill, is_null, is_one;

  always_comb begin
    is_valid = '0;
    is_ill   = '0;
    is_null  = '0;
    is_one   = '0;
    for (int i = 0; i < 3; i++) begin
      is_valid[i] = stable[i] && ((word[i] == DR_ZERO) || (word[i] == DR_ONE));
      is_ill[i]   = stable[i] && (word[i] == DR_ILL);
      is_null[i]  = stable[i] && (word[i] == DR_NULL);
      is_one[i]   = stable[i] && (word[i] == DR_ONE);
    end
  end

  state_t             state_q, state_d;
  ph_idx_t            exp_q, exp_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         strobe_q, strobe_d;
  logic               bit_q, bit_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [2:0]         exp_oh;

  assign exp_oh = 3'b001 << exp_q;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    strobe_d = '0;
    bit_d    = bit_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if ((|is_ill) || (|(is_valid & ~exp_oh))) begin
          state_d = ERR;
        end else if ((|(is_valid & exp_oh)) && (&(is_null | exp_oh))) begin
          state_d  = EXEC;
          strobe_d = exp_oh;
          bit_d    = |(is_one & exp_oh);
        end
      end
      EXEC: begin
        if (op_done) begin
          state_d = WAIT_NULL;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_NULL: begin
        // Any other phase going non-NULL before the served one returns to NULL
        // means the ring lost its token ordering.
        if (|(stable & ~is_null & ~exp_oh)) begin
          state_d = ERR;
        end else if (&is_null) begin
          state_d = IDLE;
          exp_d   = ph_inc(exp_q);
          if (exp_q == PH2) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
    ack_d = (state_d == WAIT_NULL);
    err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_q    <= PH0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      bit_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      bit_q    <= bit_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign ack       = ack_q;
  assign ph_strobe = strobe_q;
  assign ph_bit    = bit_q;
  assign err       = err_q;
  assign cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_phase_rx.sv
// Self-checking bench for phase_rx: vector table of ring rounds, strobe scoreboard,
// directed sequences for timing, error, glitch, timeout and async reset.
module tb_phase_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ph_in [3];
  logic       op_done = 1'b0;
  logic       ack;
  logic [2:0] ph_strobe;
  logic       ph_bit;
  logic       err;
  logic [7:0] cyc_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int exp_cnt  = 0;
  int idx;
  bit seen;

  typedef struct {
    logic [2:0] strobe;
    logic       bit_v;
  } sb_t;

  typedef struct {
    int         ph;
    logic [1:0] dr;
    logic [2:0] strobe;
    logic       bit_v;
  } vec_t;

  sb_t  sb_q [$];
  sb_t  e;
  vec_t vecs [6];

  phase_rx #(.SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ph0(ph_in[0]), .ph1(ph_in[1]), .ph2(ph_in[2]),
    .op_done(op_done), .ack(ack), .ph_strobe(ph_strobe), .ph_bit(ph_bit),
    .err(err), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t got;
    if (rst_n && (ph_strobe != 3'b000)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, ph_strobe}, 32'd0);
      end else begin
        got = sb_q.pop_front();
        check("sb_strobe", {29'd0, ph_strobe}, {29'd0, got.strobe});
        check("sb_ph_bit", {31'd0, ph_bit}, {31'd0, got.bit_v});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    op_done = 1'b0;
    for (int i = 0; i < 3; i++) ph_in[i] = 2'b00;
    tick(2);
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_strobe(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ph_strobe != 3'b000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input logic val, input string name);
    for (int i = 0; i < 20; i++) begin
      if (ack === val) break;
      tick();
    end
    check(name, {31'd0, ack}, {31'd0, val});
  endtask

  task automatic do_phase(input int p, input logic [1:0] v, input logic [2:0] es,
                          input logic eb, input bit rel);
    sb_t x;
    bit  got;
    x.strobe = es;
    x.bit_v  = eb;
    sb_q.push_back(x);
    ph_in[p] = v;
    wait_strobe(got);
    check("strobe_seen", {31'd0, got}, 32'd1);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("ack_after_done", {31'd0, ack}, 32'd1);
    if (rel) begin
      ph_in[p] = 2'b00;
      wait_ack(1'b0, "ack_drop");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 2'b01, 3'b001, 1'b0};
    vecs[1] = '{1, 2'b10, 3'b010, 1'b1};
    vecs[2] = '{2, 2'b01, 3'b100, 1'b0};
    vecs[3] = '{0, 2'b10, 3'b001, 1'b1};
    vecs[4] = '{1, 2'b01, 3'b010, 1'b0};
    vecs[5] = '{2, 2'b10, 3'b100, 1'b1};

    do_reset();
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_strobe", {29'd0, ph_strobe}, 32'd0);
    check("rst_bit", {31'd0, ph_bit}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cnt", {24'd0, cyc_cnt}, 32'd0);

    // Exact cycle timing of the first handshake.
    e = '{3'b001, 1'b1};
    sb_q.push_back(e);
    ph_in[0] = 2'b10;
    tick(3);
    check("t1_no_early_strobe", {29'd0, ph_strobe}, 32'd0);
    tick();
    check("t1_strobe_c4", {29'd0, ph_strobe}, 32'd1);
    check("t1_bit", {31'd0, ph_bit}, 32'd1);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check("t1_ack_rise", {31'd0, ack}, 32'd1);
    check("t1_strobe_one_cycle", {29'd0, ph_strobe}, 32'd0);
    ph_in[0] = 2'b00;
    tick(3);
    check("t1_ack_hold", {31'd0, ack}, 32'd1);
    tick();
    check("t1_ack_fall", {31'd0, ack}, 32'd0);

    // op_done in IDLE is ignored; then 256 table-driven rounds wrap cyc_cnt.
    do_reset();
    op_done = 1'b1;
    tick(4);
    check("op_done_idle_ack", {31'd0, ack}, 32'd0);
    check("op_done_idle_strobe", {29'd0, ph_strobe}, 32'd0);
    op_done = 1'b0;
    exp_cnt = 0;
    for (int r = 0; r < 257; r++) begin
      for (int i = 0; i < 3; i++) begin
        idx = (r % 2) * 3 + i;
        do_phase(vecs[idx].ph, vecs[idx].dr, vecs[idx].strobe, vecs[idx].bit_v, 1'b1);
        if (r == 0 && i == 1) check("cnt_mid_round", {24'd0, cyc_cnt}, 32'd0);
      end
      exp_cnt = (exp_cnt + 1) % 256;
      check("cyc_cnt", {24'd0, cyc_cnt}, exp_cnt);
    end

    // Async reset while ack is high in WAIT_NULL.
    do_phase(0, 2'b01, 3'b001, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ack", {31'd0, ack}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    check("async_cnt", {24'd0, cyc_cnt}, 32'd0);
    ph_in[0] = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick();
    do_phase(0, 2'b10, 3'b001, 1'b1, 1'b1);
    check("post_rst_err", {31'd0, err}, 32'd0);

    // Wrong phase first: sticky ERR until reset.
    do_reset();
    ph_in[1] = 2'b01;
    tick(6);
    check("wrong_ph_err", {31'd0, err}, 32'd1);
    check("wrong_ph_ack", {31'd0, ack}, 32'd0);
    ph_in[1] = 2'b00;
    tick(6);
    ph_in[0] = 2'b10;
    tick(6);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("err_sticky_ack", {31'd0, ack}, 32'd0);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // Illegal codeword held long enough to pass the filter.
    ph_in[0] = 2'b11;
    tick(3);
    check("ill_not_yet", {31'd0, err}, 32'd0);
    tick();
    check("ill_err", {31'd0, err}, 32'd1);

    // One-cycle illegal glitch is filtered out.
    do_reset();
    ph_in[0] = 2'b11;
    tick();
    do_phase(0, 2'b10, 3'b001, 1'b1, 1'b1);
    check("glitch_no_err", {31'd0, err}, 32'd0);

    // Timeout: ERR appears at EXEC cycle 256, counting the strobe cycle as 1.
    do_reset();
    e = '{3'b001, 1'b0};
    sb_q.push_back(e);
    ph_in[0] = 2'b01;
    wait_strobe(seen);
    check("tmo_strobe_seen", {31'd0, seen}, 32'd1);
    tick(254);
    check("tmo_c255_err", {31'd0, err}, 32'd0);
    tick();
    check("tmo_c256_err", {31'd0, err}, 32'd1);
    check("tmo_ack", {31'd0, ack}, 32'd0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/phase_rx.md
# phase_rx

Clocked receiver for the dual-rail phase ring. It consumes the PH0/PH1/PH2 four-phase dual-rail tokens, synchronises them into the `clk` domain and issues one-cycle strobes to the synchronous datapath. It drives the single `ack` back into the ring's Muller C-elements. It sits between the asynchronous phase generator and the clocked execution unit, closing the ring's handshake from the synchronous side.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages per input bit; legal range ≥ 2.
- TIMEOUT, 255: maximum `clk` cycles spent in EXEC waiting for `op_done`.
- CNT_W, 8: width of `cyc_cnt`.

Ports:
- clk  in  1  single clock for all state.
- rst_n  in  1  reset, asynchronous and active-low.
- ph0  in  2  dual-rail PH0 token from the ring; asynchronous to `clk`.
- ph1  in  2  dual-rail PH1 token; asynchronous.
- ph2  in  2  dual-rail PH2 token; asynchronous.
- op_done  in  1  datapath has finished the work for the current strobe.
- ack  out  1  four-phase acknowledge to the ring.
- ph_strobe  out  3  one-hot, one-cycle pulse; bit i corresponds to PHi.
- ph_bit  out  1  logic value decoded from the accepted codeword.
- err  out  1  sticky protocol error.
- cyc_cnt  out  CNT_W  count of completed PH0→PH1→PH2 rounds.

## Operation
Dual-rail encoding:
- 00 = NULL.
- 01 = logic 0.
- 10 = logic 1.
- 11 = illegal.

Each 2-bit input goes through SYNC_STAGES flops, then a stability filter. A codeword counts only when it is identical on two consecutive synchronised samples. This masks inter-rail skew.

FSM states:
- IDLE: `ack` = 0. Waits until exactly one phase carries a stable valid codeword and all other phases are NULL.
  - If that phase matches `exp_ph`: load `ph_bit` and go to EXEC. The matching `ph_strobe` bit pulses for the first cycle in EXEC.
  - Illegal codeword (11) on any phase, more than one phase valid, or a valid phase ≠ `exp_ph`: go to ERR.
- EXEC: waits for `op_done`. `op_done` = 1 in the strobe cycle itself is accepted.
  - On `op_done`: go to WAIT_NULL.
  - If TIMEOUT cycles pass without `op_done`: go to ERR.
- WAIT_NULL: `ack` = 1. Waits until the filtered value of all three phases is NULL.
  - Then go to IDLE with `ack` = 0 and `exp_ph` advanced: PH0→PH1→PH2→PH0.
  - On the PH2→PH0 advance, `cyc_cnt` increments, wrapping modulo 2^CNT_W.
  - While in this state, a non-NULL codeword on a phase other than the one just served goes to ERR.
- ERR: `err` = 1, `ack` = 0, no strobes. Only reset leaves ERR.

Rules:
- `op_done` outside EXEC is ignored.
- Reset mid-handshake drops `ack` asynchronously; the ring's own reset restores its token.
- Reset values: FSM = IDLE, `exp_ph` = PH0, `ack` = 0, `ph_strobe` = 000, `ph_bit` = 0, `err` = 0, `cyc_cnt` = 0, synchroniser/filter flops = 00.

## Timing
- Input edge to accepted codeword: SYNC_STAGES + 1 cycles (the filter adds one cycle).
- Codeword accepted in IDLE at cycle N: `ph_strobe` = 1 at N+1 only.
- `op_done` high at cycle M in EXEC: `ack` = 1 at M+1; this output is registered.
- All phases NULL after filtering at cycle K in WAIT_NULL: `ack` = 0 at K+1. The next strobe comes at K+2 at the earliest.
- Minimum full per-phase handshake with SYNC_STAGES = 2: 2×(2+1) + 4 = 10 cycles.
- TIMEOUT counter counts from the first EXEC cycle; with `op_done` never asserted, ERR is entered at EXEC cycle TIMEOUT+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `phase_pkg`:
  - state enum {IDLE, EXEC, WAIT_NULL, ERR};
  - constants DR_NULL = 2'b00, DR_ZERO = 2'b01, DR_ONE = 2'b10, DR_ILL = 2'b11;
  - phase index type (0..2) with an increment function that wraps 2→0.
- Sub-module `dr_sync`: a SYNC_STAGES-deep synchroniser plus the two-sample stability filter for one 2-bit dual-rail bus. Instantiate it three times.

## Test plan
- Reset, then PH0 = 10 held: `ph_strobe` = 001 at cycle 4 after the edge, `ph_bit` = 1. With `op_done` pulsed in that strobe cycle, `ack` = 1 next cycle. PH0 → 00 drops `ack` 4 cycles later.
- Full round PH0 = 01, PH1 = 10, PH2 = 01, each with its handshake: strobes 001, 010, 100 and `ph_bit` 0, 1, 0. `cyc_cnt` goes 0→1 after the PH2 NULL. Repeat 256 rounds with CNT_W = 8: `cyc_cnt` wraps to 0.
- After reset, PH1 = 01 arrives first: ERR entered, `err` = 1, `ack` = 0, no strobe; stays in ERR until `rst_n` is pulsed.
- PH0 = 11 held for 2 synchronised samples: `err` = 1. A single-cycle 11 glitch between 00 and 10 is filtered out, with no error and a normal strobe.
- Strobe issued, `op_done` never asserted, TIMEOUT = 255: `err` = 1 at EXEC cycle 256 and `ack` stays 0.
- `rst_n` asserted while `ack` = 1 in WAIT_NULL: `ack`, `err` and `cyc_cnt` go to 0 immediately, without waiting for a clock edge. After release, PH0 = 10 is accepted normally.
